piezo_tone_player: RTL

//  Parametrised successor to the fixed-pitch piezo driver. Plays one note per request:
//   - 12 semitones plus rest, over 4 octaves (4..7), for a duration counted in ms ticks.

---
 rtl/piezo_tone_player.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/piezo_tone_player.sv
`default_nettype none
// piezo_tone_player: one-note-per-request square-wave piezo driver (12 semitones + rest, octaves 4..7).
// Optional macro PIEZO_GAP_EN adds a silent GAP of GAP_TK ticks after every non-empty note.
module piezo_tone_player #(
  parameter int CLK_HZ  = 1_000_000,
  parameter int TICK_HZ = 1000,
  parameter int DUR_W   = 10,
  parameter int GAP_TK  = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       note,
  input  logic [1:0]       octave,
  input  logic [DUR_W-1:0] dur,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             piezo
);

  localparam int TICK_CYC = CLK_HZ / TICK_HZ;
  localparam int TK_W     = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam longint unsigned F_CHZ [12] = '{26163, 27718, 29366, 31113, 32963, 34923,
                                             36999, 39200, 41530, 44000, 46616, 49388};

  function automatic longint unsigned calc_half(input longint unsigned f);
    return (longint'(CLK_HZ) * 64'd100 + f) / (64'd2 * f);
  endfunction

  // C4 has the lowest pitch, hence the longest half period
  localparam longint unsigned HALF_MAX = calc_half(F_CHZ[0]);
  localparam int PH_W = $clog2(HALF_MAX);

`ifdef PIEZO_GAP_EN
  localparam int GP_W = (GAP_TK > 1) ? $clog2(GAP_TK + 1) : 1;
  typedef enum logic [1:0] {S_IDLE, S_TONE, S_GAP} state_t;
  logic [GP_W-1:0] gap_q;
`else
  typedef enum logic [0:0] {S_IDLE, S_TONE} state_t;
`endif

  state_t           state;
  logic [3:0]       note_q;
  logic [1:0]       oct_q;
  logic [DUR_W-1:0] rem_q;
  logic [TK_W-1:0]  tick_q;
  logic [PH_W-1:0]  phase_q;
  logic             empty_q;

  logic [PH_W-1:0] half_tab [16];
  logic [PH_W-1:0] half;
  logic            is_rest;
  logic            tick_wrap;

  for (genvar i = 0; i < 16; i++) begin : g_half
    if (i < 12) begin : g_pitch
      assign half_tab[i] = PH_W'(calc_half(F_CHZ[i]));
    end else begin : g_rest
      assign half_tab[i] = '0;
    end
  end

  assign half      = half_tab[note_q] >> oct_q;
  assign is_rest   = note_q[3] & note_q[2];
  assign tick_wrap = (tick_q == TK_W'(TICK_CYC - 1));
  assign ready     = (state == S_IDLE);
  assign busy      = ~ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      note_q  <= '0;
      oct_q   <= '0;
      rem_q   <= '0;
      tick_q  <= '0;
      phase_q <= '0;
      empty_q <= 1'b0;
      done    <= 1'b0;
      piezo   <= 1'b0;
`ifdef PIEZO_GAP_EN
      gap_q   <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // an empty note completes one cycle after its accept edge
          done    <= empty_q;
          empty_q <= 1'b0;
          piezo   <= 1'b0;
          if (start) begin
            note_q  <= note;
            oct_q   <= octave;
            rem_q   <= dur;
            tick_q  <= '0;
            phase_q <= '0;
            if (dur == '0) empty_q <= 1'b1;
            else           state   <= S_TONE;
          end
        end
        S_TONE: begin
          tick_q <= tick_wrap ? '0 : tick_q + TK_W'(1);
          if (!is_rest) begin
            if (phase_q == half - PH_W'(1)) begin
              phase_q <= '0;
              piezo   <= ~piezo;
            end else begin
              phase_q <= phase_q + PH_W'(1);
            end
          end
          // expiry overrides any toggle scheduled on the same edge
          if (tick_wrap) begin
            if (rem_q == DUR_W'(1)) begin
              piezo   <= 1'b0;
              phase_q <= '0;
`ifdef PIEZO_GAP_EN
              state   <= S_GAP;
              gap_q   <= GP_W'(GAP_TK);
`else
              state   <= S_IDLE;
              done    <= 1'b1;
`endif
            end else begin
              rem_q <= rem_q - DUR_W'(1);
            end
          end
        end
`ifdef PIEZO_GAP_EN
        S_GAP: begin
          piezo  <= 1'b0;
          tick_q <= tick_wrap ? '0 : tick_q + TK_W'(1);
          if (tick_wrap) begin
            if (gap_q == GP_W'(1)) begin
              state <= S_IDLE;
              done  <= 1'b1;
            end else begin
              gap_q <= gap_q - GP_W'(1);
            end
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
